// File: rtl/core_pkg.sv
// Shared types and sizing for the 8-bit core's write-back register file.
package core_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  // One write-back request as held in the WB latch.
  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
    word_t    data;
  } wb_req_t;

  // True when idx names an implemented register (NUM_REGS may be below 2**ADDR_W).
  function automatic logic idx_in_range(reg_idx_t idx, int unsigned nregs);
    return 32'(idx) < nregs;
  endfunction

endpackage

// File: rtl/wb_register_file_if.sv
// Write-back request and read-port signals between the core pipeline and the register file.
interface wb_register_file_if;
  import core_pkg::*;

  logic     stall;
  logic     flush;
  logic     regWrite;
  reg_idx_t writeReg;
  word_t    writeData;
  reg_idx_t readRegA;
  reg_idx_t readRegB;
  word_t    readDataA;
  word_t    readDataB;
  logic     wbPending;

  modport master (
    output stall, flush, regWrite, writeReg, writeData, readRegA, readRegB,
    input  readDataA, readDataB, wbPending
  );

  modport slave (
    input  stall, flush, regWrite, writeReg, writeData, readRegA, readRegB,
    output readDataA, readDataB, wbPending
  );

endinterface

// File: rtl/wb_bypass_read.sv
// Combinational read port: hardwired R0, range check, WB-latch bypass, then array.
module wb_bypass_read #(
  parameter int unsigned NUM_REGS = core_pkg::NUM_REGS,
  parameter bit          ZERO_R0  = 1'b1
) (
  input  core_pkg::reg_idx_t i_idx,
  input  core_pkg::wb_req_t  i_wb,
  input  core_pkg::word_t    i_regs [NUM_REGS],
  output core_pkg::word_t    o_data
);
  import core_pkg::*;

  // Priority mux so the pending write hides the one-edge commit delay from readers.
  always_comb begin
    o_data = '0;
    if (ZERO_R0 && (i_idx == '0)) begin
      o_data = '0;
    end else if (!idx_in_range(i_idx, NUM_REGS)) begin
      o_data = '0;
    end else if (i_wb.valid && (i_wb.idx == i_idx)) begin
      o_data = i_wb.data;
    end else begin
      o_data = i_regs[i_idx];
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage register file: requests are latched on one edge and committed
// to the flop array on the next; both read ports bypass the pending latch.
module wb_register_file #(
  parameter int unsigned NUM_REGS = core_pkg::NUM_REGS,
  parameter bit          ZERO_R0  = 1'b1
) (
  input logic               clk,
  input logic               rstN,
  wb_register_file_if.slave wb
);
  import core_pkg::*;

  word_t   r_regs [NUM_REGS];
  wb_req_t r_wb;
  wb_req_t w_wb_next;
  logic    w_req_ok;

  // Qualify the incoming request: flushed, R0 (when hardwired) and out-of-range writes never latch.
  always_comb begin
    w_req_ok = wb.regWrite & ~wb.flush & idx_in_range(wb.writeReg, NUM_REGS);
    if (ZERO_R0 && (wb.writeReg == '0)) begin
      w_req_ok = 1'b0;
    end
    w_wb_next = '{valid: w_req_ok, idx: wb.writeReg, data: wb.writeData};
  end

  // WB latch: captures the qualified request on every non-stalled edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wb <= '0;
    end else if (!wb.stall) begin
      r_wb <= w_wb_next;
    end
  end

  // Array commit: the previous latch contents land here on the same edge a new request is captured.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (!wb.stall && r_wb.valid) begin
      r_regs[r_wb.idx] <= r_wb.data;
    end
  end

  wb_bypass_read #(
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0)
  ) u_read_a (
    .i_idx  (wb.readRegA),
    .i_wb   (r_wb),
    .i_regs (r_regs),
    .o_data (wb.readDataA)
  );

  wb_bypass_read #(
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0)
  ) u_read_b (
    .i_idx  (wb.readRegB),
    .i_wb   (r_wb),
    .i_regs (r_regs),
    .o_data (wb.readDataB)
  );

  assign wb.wbPending = r_wb.valid;

endmodule
